// File: rtl/up_sampler.sv
// rtl/up_sampler.sv - linear-interpolating upsampler by L = 2**LOG2_L
//
// Rebuilds a full-rate stream from decimated samples. Each accepted sample
// after the first produces L outputs walking linearly (floor-rounded) from
// the previous sample toward the new one.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   en         in   block enable; low freezes all state
//   data_in    in   signed decimated input sample
//   valid_in   in   data_in valid
//   ready_in   out  sample accepted when valid_in & ready_in
//   data_out   out  signed interpolated sample (registered)
//   valid_out  out  one-cycle pulse per output sample
module up_sampler #(
  parameter int Width  = 10,
  parameter int LOG2_L = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [Width-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_in,
  output logic [Width-1:0] data_out,
  output logic             valid_out
);

  localparam int AccW = Width + LOG2_L + 1;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    PRIMED = 2'd1,
    EMIT   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [Width-1:0]    prev_q, prev_d;
  logic [Width-1:0]    cur_q, cur_d;
  logic [LOG2_L-1:0]   k_q, k_d;
  logic [AccW-1:0]     acc_q, acc_d;
  logic [Width-1:0]    data_out_q, data_out_d;
  logic                valid_out_q, valid_out_d;

  logic                k_last;
  logic                accept;
  logic [Width:0]      delta;
  logic [AccW-1:0]     delta_ext;
  logic [AccW-1:0]     prev_scaled;
  logic [AccW-1:0]     cur_scaled;

  // k counts 0..L-1, so the last step is the all-ones value.
  assign k_last   = &k_q;
  assign ready_in = ~rst & en & ((state_q != EMIT) | k_last);
  assign accept   = valid_in & ready_in;

  // prev and cur are stable for a whole burst, so the slope is recomputed
  // from them each cycle instead of being stored.
  assign delta       = {cur_q[Width-1], cur_q} - {prev_q[Width-1], prev_q};
  assign delta_ext   = {{LOG2_L{delta[Width]}}, delta};
  assign prev_scaled = {prev_q[Width-1], prev_q, {LOG2_L{1'b0}}};
  assign cur_scaled  = {cur_q[Width-1], cur_q, {LOG2_L{1'b0}}};

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    cur_d       = cur_q;
    k_d         = k_q;
    acc_d       = acc_q;
    data_out_d  = data_out_q;
    valid_out_d = 1'b0;
    if (en) begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            prev_d  = data_in;
            state_d = PRIMED;
          end
        end
        PRIMED: begin
          if (accept) begin
            cur_d   = data_in;
            acc_d   = prev_scaled;
            k_d     = '0;
            state_d = EMIT;
          end
        end
        EMIT: begin
          // acc carries LOG2_L fraction bits; dropping them is a floor.
          valid_out_d = 1'b1;
          data_out_d  = acc_q[Width+LOG2_L-1:LOG2_L];
          acc_d       = acc_q + delta_ext;
          k_d         = k_q + LOG2_L'(1);
          if (k_last) begin
            prev_d = cur_q;
            if (accept) begin
              // Next segment starts at the old cur with no idle cycle.
              cur_d = data_in;
              acc_d = cur_scaled;
              k_d   = '0;
            end else begin
              state_d = PRIMED;
            end
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      prev_q      <= '0;
      cur_q       <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      cur_q       <= cur_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;

endmodule

// File: tb/tb_up_sampler.sv
// tb/tb_up_sampler.sv - self-checking bench for up_sampler
module tb_up_sampler;

  localparam int Width  = 10;
  localparam int LOG2_L = 2;
  localparam int L      = 1 << LOG2_L;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [Width-1:0] data_in;
  logic             valid_in;
  logic             ready_in;
  logic [Width-1:0] data_out;
  logic             valid_out;

  up_sampler #(.Width(Width), .LOG2_L(LOG2_L)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .data_out  (data_out),
    .valid_out (valid_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: pending outputs, last input sample, last output value.
  int exp_q[$];
  bit have_prev = 0;
  int prev_s    = 0;
  int last_out  = 0;

  int got[$];
  int got_cyc[$];

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int floor_div(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  // One clock cycle: drive at negedge, check ready, update model, check the
  // registered outputs at the following negedge.
  task automatic step(input bit r, input bit e, input bit v, input int d, output bit acc);
    bit exp_v;
    int exp_d;
    rst      = r;
    en       = e;
    valid_in = v;
    data_in  = Width'(d);
    #1;
    check("ready_in", int'(ready_in), int'(!r && e && exp_q.size() <= 1));
    exp_v = !r && e && exp_q.size() > 0;
    acc   = 1'b0;
    if (r) begin
      exp_q.delete();
      have_prev = 0;
      last_out  = 0;
    end else if (v && ready_in) begin
      acc = 1'b1;
      if (have_prev)
        for (int j = 0; j < L; j++)
          exp_q.push_back(prev_s + floor_div(j * (d - prev_s), L));
      prev_s    = d;
      have_prev = 1;
    end
    exp_d = 0;
    if (exp_v) begin
      exp_d    = exp_q.pop_front();
      last_out = exp_d;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check("valid_out", int'(valid_out), int'(exp_v));
    check("data_out", int'($signed(data_out)), last_out);
    if (valid_out) begin
      got.push_back(int'($signed(data_out)));
      got_cyc.push_back(cyc);
    end
  endtask

  task automatic send(input int d);
    bit acc;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) step(0, 1, 1, d, acc);
    if (!acc) check("send_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(0, 1, 0, 0, acc);
  endtask

  task automatic do_reset();
    bit acc;
    for (int i = 0; i < 2; i++) step(1, 1, 1, 0, acc);
    got.delete();
    got_cyc.delete();
  endtask

  task automatic check_got(input string tag, input int exp[$]);
    check({tag, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check(tag, got[i], exp[i]);
  endtask

  initial begin
    bit acc;
    bit r_v, r_valid;
    int r_data;
    int want[$];

    rst = 1'b1; en = 1'b1; valid_in = 1'b1; data_in = '0;
    @(negedge clk);

    // Reset held three cycles with valid_in high.
    for (int i = 0; i < 3; i++) step(1, 1, 1, 5, acc);
    check("rst_data_out", int'(data_out), 0);
    check("rst_valid_out", int'(valid_out), 0);
    check("rst_ready_in", int'(ready_in), 0);
    rst = 1'b0; valid_in = 1'b0;
    #1;
    check("ready_after_rst", int'(ready_in), 1);

    // Ramp 0 -> 8; the first sample only primes.
    got.delete(); got_cyc.delete();
    send(0);
    idle(3);
    check("prime_no_output", got.size(), 0);
    send(8);
    idle(6);
    want = {0, 2, 4, 6};
    check_got("ramp", want);

    // Negative slope with floor rounding.
    do_reset();
    send(8); send(-3); idle(6);
    want = {8, 5, 2, -1};
    check_got("neg_slope", want);

    // Full-scale extremes.
    do_reset();
    send(-512); send(511); idle(6);
    want = {-512, -257, -1, 255};
    check_got("extremes", want);

    // Back-to-back with valid_in held high: gapless output.
    do_reset();
    send(0); send(8); send(16); idle(6);
    want = {0, 2, 4, 6, 8, 10, 12, 14};
    check_got("b2b", want);
    if (got_cyc.size() == 8) check("b2b_gapless", got_cyc[7] - got_cyc[0], 7);

    // Enable gap after two outputs of the 0 -> 8 ramp.
    do_reset();
    send(0); send(8); idle(2);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 99, acc);
    idle(4);
    want = {0, 2, 4, 6};
    check_got("en_gap", want);

    // Reset mid-EMIT drops the rest; the next sample primes only.
    do_reset();
    send(0); send(8); idle(1);
    step(1, 1, 0, 0, acc);
    idle(4);
    send(5); idle(2);
    send(9); idle(6);
    want = {0, 5, 6, 7, 8};
    check_got("rst_mid_emit", want);

    // Randomized traffic against the model; the sender holds a pending sample.
    r_valid = 1'b0;
    r_data  = 0;
    for (int i = 0; i < 4000; i++) begin
      r_v = ($urandom_range(0, 63) == 0);
      if (!r_valid && $urandom_range(0, 1) == 1) begin
        r_valid = 1'b1;
        case ($urandom_range(0, 7))
          0:       r_data = -512;
          1:       r_data = 511;
          default: r_data = int'($urandom_range(0, 1023)) - 512;
        endcase
      end
      step(r_v, $urandom_range(0, 7) != 0, r_valid, r_data, acc);
      if (acc) r_valid = 1'b0;
    end
    idle(8);
    check("final_drain", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
